dmem_arbiter_d0: RTL and testbench

//  Shares the single-port, synchronous-read data RAM (ram_sync_read_d0) between two requesters:

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/dmem_arbiter_d0.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter_d0.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter: FSM encoding and port indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on contention the port that was
// not served last wins. Purely combinational.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = P0;
    if (req_i == 2'b11) begin
      grant_o = ~last_i;
    end else if (req_i[1]) begin
      grant_o = P1;
    end
  end

endmodule

// File: rtl/dmem_arbiter_d0.sv
// Arbitrates the single-port synchronous-read data RAM between the cache side (port 0)
// and the bus/snoop side (port 1); one access in flight, registered ack/rdata returned.
module dmem_arbiter_d0
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              busy,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_dout
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_din_q, mem_din_d;
  logic [DWIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              arb_grant, arb_valid;

  rr_arbiter2 u_arb (
    .req_i   ({req1, req0}),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    unique case (state_q)
      StIdle: begin
        // The cycle carrying the previous ack never grants, so a held req is seen as new later.
        if (arb_valid && !ack0_q && !ack1_q) begin
          gnt_d      = arb_grant;
          we_d       = (arb_grant == P1) ? we1 : we0;
          mem_we_d   = (arb_grant == P1) ? we1 : we0;
          mem_addr_d = (arb_grant == P1) ? addr1 : addr0;
          mem_din_d  = (arb_grant == P1) ? wdata1 : wdata0;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        mem_we_d = 1'b0;
        state_d  = StResp;
      end
      StResp: begin
        if (gnt_q == P0) begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = mem_dout;
        end else begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = mem_dout;
        end
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      last_q     <= P1;
      gnt_q      <= P0;
      we_q       <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = busy_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_dmem_arbiter_d0.sv
// Directed bench for dmem_arbiter_d0 with a behavioural 8x32 synchronous-read RAM attached.
module tb_dmem_arbiter_d0;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [2:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, busy, mem_we;
  logic [31:0] rdata0, rdata1, mem_din, mem_dout;
  logic [2:0]  mem_addr;

  logic [31:0] ram [0:7] = '{default: '0};

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  dmem_arbiter_d0 #(.AWIDTH(3), .DWIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request on one port; checks ack latency, ack width, mem_we count and idle other port.
  task automatic access(input string tag, input bit port, input bit we, input logic [2:0] a,
                        input logic [31:0] d, input bit scramble,
                        output logic [2:0] we_addr, output logic [31:0] we_din);
    int lat = -1;
    int wecnt = 0;
    int other = 0;
    we_addr = 'x;
    we_din  = 'x;
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clock);
      if (mem_we) begin
        wecnt++;
        we_addr = mem_addr;
        we_din  = mem_din;
      end
      if (scramble && cyc == 1) begin
        if (port) begin addr1 = ~a; wdata1 = ~d; end
        else begin addr0 = ~a; wdata0 = ~d; end
      end
      if (port ? ack0 : ack1) other++;
      if (port ? ack1 : ack0) begin
        lat = cyc;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk({tag, " ack latency"}, lat, 3);
    chk({tag, " mem_we cycles"}, wecnt, we ? 1 : 0);
    chk({tag, " other ack"}, other, 0);
    @(negedge clock);
    chk({tag, " ack width"}, {31'd0, port ? ack1 : ack0}, 32'd0);
  endtask

  initial begin
    logic [2:0]  wa;
    logic [31:0] wd;
    int          order [4];
    int          when [4];
    logic [31:0] seen [4];
    int          n;
    int          prev_ack;
    int          both;
    int          exp_order [4] = '{0, 1, 0, 1};
    int          exp_when [4]  = '{3, 7, 11, 15};

    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst ack0", {31'd0, ack0}, 0);
    chk("rst ack1", {31'd0, ack1}, 0);
    chk("rst rdata0", rdata0, 0);
    chk("rst rdata1", rdata1, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst mem_we", {31'd0, mem_we}, 0);
    chk("rst mem_addr", {29'd0, mem_addr}, 0);
    chk("rst mem_din", mem_din, 0);
    reset = 1'b0;
    @(negedge clock);

    // Test 1: port 0 write
    access("t1 wr", 1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, wa, wd);
    chk("t1 mem_addr", {29'd0, wa}, 3);
    chk("t1 mem_din", wd, 32'hDEAD_BEEF);
    chk("t1 ram[3]", ram[3], 32'hDEAD_BEEF);
    chk("t1 rdata0 kept", rdata0, 0);

    // Test 2: port 0 read-back
    access("t2 rd", 1'b0, 1'b0, 3'd3, 32'h0, 1'b0, wa, wd);
    chk("t2 rdata0", rdata0, 32'hDEAD_BEEF);
    chk("t2 rdata1", rdata1, 0);

    // Preload for test 3
    access("pre a1", 1'b0, 1'b1, 3'd1, 32'hA1A1_A1A1, 1'b0, wa, wd);
    access("pre b2", 1'b1, 1'b1, 3'd2, 32'hB2B2_B2B2, 1'b0, wa, wd);

    // Test 3: both ports held high from reset
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    @(negedge clock);
    reset = 1'b0;
    n = 0; prev_ack = 0; both = 0;
    for (int cyc = 1; cyc <= 24 && n < 4; cyc++) begin
      @(negedge clock);
      if (ack0 && ack1) both++;
      if (ack0 || ack1) begin
        if (prev_ack != 0) both++;
        order[n] = ack1 ? 1 : 0;
        when[n]  = cyc;
        seen[n]  = ack1 ? rdata1 : rdata0;
        n++;
        prev_ack = 1;
      end else begin
        prev_ack = 0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("t3 ack count", n, 4);
    chk("t3 overlap/width", both, 0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("t3 order[%0d]", i), order[i], exp_order[i]);
      chk($sformatf("t3 when[%0d]", i), when[i], exp_when[i]);
      chk($sformatf("t3 data[%0d]", i), seen[i],
          (exp_order[i] == 0) ? 32'hA1A1_A1A1 : 32'hB2B2_B2B2);
    end
    @(negedge clock);
    @(negedge clock);

    // Test 4: port 1 write, request fields changed after grant
    access("t4 wr", 1'b1, 1'b1, 3'd7, 32'h1234_5678, 1'b1, wa, wd);
    chk("t4 mem_addr", {29'd0, wa}, 7);
    chk("t4 mem_din", wd, 32'h1234_5678);
    chk("t4 ram[7]", ram[7], 32'h1234_5678);
    chk("t4 ram[0]", ram[0], 0);
    chk("t4 rdata1 kept", rdata1, 32'hB2B2_B2B2);

    // Test 5: reset during ACCESS of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wdata0 = 32'hCAFE_F00D;
    @(negedge clock);
    chk("t5 in access", {31'd0, mem_we}, 1);
    reset = 1'b1;
    #1;
    chk("t5 mem_we", {31'd0, mem_we}, 0);
    chk("t5 busy", {31'd0, busy}, 0);
    chk("t5 ack0", {31'd0, ack0}, 0);
    chk("t5 mem_addr", {29'd0, mem_addr}, 0);
    chk("t5 rdata1", rdata1, 0);
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk("t5 ram[5]", ram[5], 0);
    access("t5 rd3", 1'b0, 1'b0, 3'd3, 32'h0, 1'b0, wa, wd);
    chk("t5 rdata0 a3", rdata0, 32'hDEAD_BEEF);
    access("t5 rd5", 1'b0, 1'b0, 3'd5, 32'h0, 1'b0, wa, wd);
    chk("t5 rdata0 a5", rdata0, 0);

    // Test 6: port 1 keeps req high one cycle past its ack -> second grant
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd7;
    n = 0; both = 0;
    for (int cyc = 1; cyc <= 12 && n < 2; cyc++) begin
      @(negedge clock);
      if (mem_we) both++;
      if (ack1) begin
        when[n] = cyc;
        seen[n] = rdata1;
        n++;
      end
      if (cyc == 5) begin
        chk("t6 busy regrant", {31'd0, busy}, 1);
        req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    chk("t6 ack count", n, 2);
    chk("t6 first ack", when[0], 3);
    chk("t6 second ack", when[1], 7);
    chk("t6 rdata1", seen[1], 32'h1234_5678);
    chk("t6 mem_we on reads", both, 0);
    @(negedge clock);
    chk("t6 idle", {30'd0, ack1, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
